// File: rtl/float_pkg.sv
// Shared float format definitions for the encoder and the float adder.
package float_pkg;

  localparam int SIGN    = 1;
  localparam int EXP_W   = 6;
  localparam int FRAC_W  = 25;
  localparam int MAG_W   = 32;
  localparam int EXP_MAX = 63;

  typedef enum logic [3:0] {
    EXACT     = 4'd0,
    OVERFLOW  = 4'd1,
    UNDERFLOW = 4'd2,
    INEXACT   = 4'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORMALIZE,
    S_ROUND,
    S_DONE
  } enc_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float_t;

endpackage

// File: rtl/float_round_rne.sv
// Round-to-nearest-even of a normalised 32-bit mantissa.
module float_round_rne
  import float_pkg::*;
(
  input  logic [MAG_W-1:0]  mag_i,
  input  logic signed [7:0] exp_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic signed [7:0] exp_o,
  output logic              inexact_o,
  output logic              zero_o
);

  logic [FRAC_W-1:0] frac_raw;
  logic              guard;
  logic              sticky;
  logic              up;

  assign frac_raw  = mag_i[30:6];
  assign guard     = mag_i[5];
  assign sticky    = |mag_i[4:0];
  assign up        = guard & (sticky | frac_raw[0]);

  // all-ones fraction wraps to zero; the carry lands in the exponent
  assign frac_o    = frac_raw + FRAC_W'(up);
  assign exp_o     = (up && (&frac_raw)) ? exp_i + 8'sd1 : exp_i;
  assign inexact_o = guard | sticky;

  // a normalised mantissa lacks its hidden 1 only for a zero input
  assign zero_o    = ~mag_i[31];

endmodule

// File: rtl/fixed_to_float_encoder.sv
// Signed fixed-point to custom float encoder with a
// bit-serial normaliser and RNE rounding.
module fixed_to_float_encoder
  import float_pkg::*;
#(
  parameter int FRAC_BITS = 0,
  parameter int BIAS      = 31
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic [0:31] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [0:31] data_out,
  output logic [0:3]  status_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic signed [7:0] EXP_INIT =
    8'(BIAS + 31 - FRAC_BITS);
  localparam logic signed [7:0] EXP_SAT = 8'(EXP_MAX);

  enc_state_e        state_q, state_d;
  logic              sign_q, sign_d;
  logic [MAG_W-1:0]  mag_q, mag_d;
  logic signed [7:0] exp_q, exp_d;
  float_t            dout_q, dout_d;
  status_e           stat_q, stat_d;

  logic [MAG_W-1:0]  din;
  logic [FRAC_W-1:0] frac_rnd;
  logic signed [7:0] exp_rnd;
  logic              inexact;
  logic              is_zero;
  float_t            res;
  status_e           res_stat;

  assign din = data_in;

  float_round_rne u_round (
    .mag_i     (mag_q),
    .exp_i     (exp_q),
    .frac_o    (frac_rnd),
    .exp_o     (exp_rnd),
    .inexact_o (inexact),
    .zero_o    (is_zero)
  );

  always_comb begin
    res      = '0;
    res_stat = EXACT;
    if (is_zero) begin
      res      = '0;
      res_stat = EXACT;
    end else if (exp_rnd >= EXP_SAT) begin
      res      = '{sign: sign_q, exp: 6'd63, frac: '0};
      res_stat = OVERFLOW;
    end else if (exp_rnd <= 8'sd0) begin
      res      = '{sign: sign_q, exp: '0, frac: '0};
      res_stat = UNDERFLOW;
    end else begin
      res      = '{sign: sign_q,
                   exp:  exp_rnd[5:0],
                   frac: frac_rnd};
      res_stat = inexact ? INEXACT : EXACT;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    dout_d  = dout_q;
    stat_d  = stat_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = din[31];
          mag_d   = din[31] ? (~din + 32'd1) : din;
          exp_d   = EXP_INIT;
          state_d = S_NORMALIZE;
        end
      end
      S_NORMALIZE: begin
        if (mag_q == '0) begin
          state_d = S_ROUND;
        end else if (mag_q[31]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'sd1;
        end
      end
      S_ROUND: begin
        dout_d  = res;
        stat_d  = res_stat;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      dout_q  <= '0;
      stat_q  <= EXACT;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      dout_q  <= dout_d;
      stat_q  <= stat_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign data_out   = dout_q;
  assign status_out = stat_q;

endmodule
